ir_key_queue: RTL

Controller between the IR frame receiver and the Avalon-MM host port. It validates each received 32-bit NEC frame, classifies it as a new key press or an auto-repeat, and queues accepted events in a small FIFO. The host sees count, overflow, error and interrupt state through a 4-word slave window, so no key press is lost when software is slow to service the interrupt.

---
 rtl/ir_key_pkg.sv | 39 +++
 rtl/ir_key_fifo.sv | 72 +++++++
 rtl/ir_key_queue.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ir_key_pkg.sv
// Shared definitions for the IR key queue: register offsets, entry layout, repeat FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ir_key_pkg;

  // Host window word offsets
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  // Queued entry: {rpt, key[7:0], custom[15:0]}
  localparam int ENTRY_W      = 25;
  localparam int ENT_CUST_LSB = 0;
  localparam int ENT_CUST_W   = 16;
  localparam int ENT_KEY_LSB  = 16;
  localparam int ENT_KEY_W    = 8;
  localparam int ENT_RPT_BIT  = 24;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } rpt_state_e;

  // NEC integrity check: the top byte must be the bitwise inverse of the key byte.
  function automatic logic frame_ok(input logic [31:0] f);
    return (f[31:24] == ~f[23:16]);
  endfunction

  function automatic logic [ENTRY_W-1:0] make_entry(input logic rpt, input logic [31:0] f);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[ENT_RPT_BIT]                  = rpt;
    e[ENT_KEY_LSB +: ENT_KEY_W]     = f[23:16];
    e[ENT_CUST_LSB +: ENT_CUST_W]   = f[15:0];
    return e;
  endfunction

endpackage

// File: rtl/ir_key_fifo.sv
// Synchronous FIFO with flush; head word is presented combinationally.
// Latency: a push is visible in count/head the cycle after it is presented.
// Backpressure: none upstream; a push while full is dropped (drop_o) unless a pop frees the slot that cycle.
//
// Ports: clk/reset_n, push_i/push_dat_i, pop_i, flush_i (wins over push and pop),
//        head_dat_o, full_o, empty_o, count_o, drop_o (push lost this cycle).
module ir_key_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 25,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~flush_i & ~do_push;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; contents are only observed through the valid count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/ir_key_queue.sv
// IR key event queue: validates NEC frames, tags auto-repeats, buffers events for an Avalon-MM host.
// Latency: frame_valid -> count updated 2 cycles later, irq 3 cycles later; reads return 1 cycle after s_read.
// Backpressure: none toward the receiver; entries arriving while the queue is full are dropped and flagged (ovf).
//
// Ports: clk, reset_n (async active-low), frame_valid/frame_data from the IR receiver,
//        s_cs_n/s_address/s_read/s_write/s_writedata/s_readdata host slave window, irq level interrupt.
module ir_key_queue
  import ir_key_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 6_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_valid,
  input  logic [31:0] frame_data,
  input  logic        s_cs_n,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int             CW        = $clog2(DEPTH) + 1;
  localparam int             TW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0]  HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  // ---------------------------------------------------------------- validation
  logic frame_good, frame_bad;
  assign frame_good = frame_valid &  frame_ok(frame_data);
  assign frame_bad  = frame_valid & ~frame_ok(frame_data);

  // ---------------------------------------------------------------- control regs
  logic irq_en_q, irq_en_d;
  logic repeat_en_q, repeat_en_d;
  logic ovf_q, ovf_d;
  logic [7:0] err_q, err_d;

  // ---------------------------------------------------------------- repeat FSM
  rpt_state_e    state_q, state_d;
  logic [23:0]   last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          push_d, push_q;
  logic          rpt_d;
  logic [ENTRY_W-1:0] entry_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = timer_q;
    push_d  = 1'b0;
    rpt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_good) begin
          push_d  = 1'b1;
          last_d  = frame_data[23:0];
          timer_d = HOLD_LOAD;
          state_d = HELD;
        end
      end
      HELD: begin
        // A good frame always keeps us in HELD, even on the cycle the timer hits zero.
        if (frame_good) begin
          timer_d = HOLD_LOAD;
          if (frame_data[23:0] == last_q) begin
            push_d = repeat_en_q;
            rpt_d  = 1'b1;
          end else begin
            push_d = 1'b1;
            last_d = frame_data[23:0];
          end
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= '0;
      timer_q <= '0;
      push_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      push_q  <= push_d;
      if (push_d) entry_q <= make_entry(rpt_d, frame_data);
    end
  end

  // ---------------------------------------------------------------- bus decode
  logic rd_en, wr_en;
  logic fifo_pop, fifo_flush;
  logic clr_ovf, clr_err;
  assign rd_en      = ~s_cs_n & s_read;
  assign wr_en      = ~s_cs_n & s_write;
  assign fifo_pop   = rd_en & (s_address == REG_DATA);
  assign fifo_flush = wr_en & (s_address == REG_CLEAR) & s_writedata[2];
  assign clr_ovf    = wr_en & (s_address == REG_CLEAR) & s_writedata[0];
  assign clr_err    = wr_en & (s_address == REG_CLEAR) & s_writedata[1];

  logic unused_wdata;
  assign unused_wdata = ^s_writedata[31:3];

  // ---------------------------------------------------------------- queue
  logic [ENTRY_W-1:0] head_dat;
  logic               fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]      fifo_count;

  ir_key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push_q),
    .push_dat_i (entry_q),
    .pop_i      (fifo_pop),
    .flush_i    (fifo_flush),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .drop_o     (fifo_drop)
  );

  // ---------------------------------------------------------------- register next state
  logic [31:0] status_w;
  logic [31:0] rdata_d;

  always_comb begin
    status_w        = '0;
    status_w[6:0]   = 7'(fifo_count);
    status_w[8]     = fifo_empty;
    status_w[9]     = fifo_full;
    status_w[10]    = ovf_q;
    status_w[23:16] = err_q;
  end

  always_comb begin
    rdata_d = s_readdata;
    if (rd_en) begin
      case (s_address)
        REG_DATA:   rdata_d = fifo_empty ? 32'h0 : {7'b0, head_dat};
        REG_STATUS: rdata_d = status_w;
        REG_CTRL:   rdata_d = {30'b0, repeat_en_q, irq_en_q};
        default:    rdata_d = 32'h0;
      endcase
    end
  end

  always_comb begin
    irq_en_d    = irq_en_q;
    repeat_en_d = repeat_en_q;
    if (wr_en && s_address == REG_CTRL) begin
      irq_en_d    = s_writedata[0];
      repeat_en_d = s_writedata[1];
    end
    // A drop on the same cycle as a clear is a fresh overflow, so it survives.
    ovf_d = ovf_q;
    if (clr_ovf)   ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
    err_d = err_q;
    if (clr_err)                        err_d = 8'h00;
    else if (frame_bad && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q    <= 1'b0;
      repeat_en_q <= 1'b1;
      ovf_q       <= 1'b0;
      err_q       <= 8'h00;
      s_readdata  <= 32'h0;
      irq         <= 1'b0;
    end else begin
      irq_en_q    <= irq_en_d;
      repeat_en_q <= repeat_en_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      s_readdata  <= rdata_d;
      // Driven from the count already visible on STATUS, so irq trails the count by one cycle.
      irq         <= irq_en_q & (fifo_count != '0);
    end
  end

endmodule
